cola_fifo_ext: RTL
==================

Name: cola_fifo_ext

Overview:
- Parametrised successor of the board-level 2^W x B FIFO, generalised in data width and depth.
- Adds the following, beyond the basic full/empty/error set:
  - occupancy count
  - programmable almost-full / almost-empty thresholds
  - separate sticky overflow/underflow flags with clear
  - registered read data with a valid strobe
- Sits behind button_regulator-style single-cycle strobes (rd/wr) in board test tops; also usable as a generic buffer between clocked blocks.

Parameters:
- B, 8, data width in bits
- W, 4, address width; depth = 2^W entries
- AF_LEVEL, 2^W-1, almost_full asserted when count >= AF_LEVEL (range 1..2^W)
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (range 0..2^W-1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- wr  in  1  write request, one cycle = one write
- rd  in  1  read request, one cycle = one read
- in  in  B  write data, sampled on clk when write accepted
- clr_err  in  1  synchronous clear of sticky overflow/underflow
- data  out  B  registered read data
- data_valid  out  1  one-cycle pulse: data updated this cycle
- count  out  W+1  current occupancy, 0..2^W
- full  out  1  count == 2^W
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky: write attempted while full and not simultaneously read
- underflow  out  1  sticky: read attempted while empty
- error  out  1  overflow | underflow

Behaviour:
- Reset (reset=0, async):
  - rd_ptr, wr_ptr, count cleared; data=0, data_valid=0
  - full=0, empty=1, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0, error=0
  - Memory contents not cleared
  - Reset mid-operation discards all entries immediately; release synchronous to next clk edge.
- Storage: 2^W x B register array; W-bit pointers wrap naturally from 2^W-1 to 0; count tracked separately in W+1 bits.
- Accept rules, evaluated on the same edge:
  - wr_ok = wr & (~full | rd_ok)
  - rd_ok = rd & ~empty
- Cases:
  - wr only, not full: mem[wr_ptr] <= in; wr_ptr+1; count+1.
  - rd only, not empty: data <= mem[rd_ptr]; rd_ptr+1; count-1; data_valid=1 next cycle.
  - wr & rd, 0<count<2^W: both performed; count unchanged.
  - wr & rd when full: read performed and write performed (slot freed same cycle); count stays 2^W; no overflow.
  - wr & rd when empty: write performed, read rejected; count becomes 1; underflow set. No bypass of in to data.
  - wr when full without rd: write dropped, memory/pointers unchanged, overflow set.
  - rd when empty without wr: nothing changes, data holds, data_valid=0, underflow set.
- Read latency: data and data_valid appear one clock after the accepting edge. data holds its last value otherwise.
- Flags full, empty, almost_full, almost_empty are combinational from registered count; they change one cycle after the accepting edge.
- Sticky errors:
  - overflow/underflow remain 1 until clr_err=1 or reset.
  - If a new error event and clr_err coincide, the flag ends at 1 (event wins).
  - error is the combinational OR of the two flags.
- wr/rd held high for N cycles = N requests; no edge detection inside (done upstream).

Test Plan (B=3, W=2, AF_LEVEL=3, AE_LEVEL=1):
- Reset, then 4 single writes of 1,2,3,4 → count 1,2,3,4; almost_empty drops after count=2; almost_full at count=3; full=1 after 4th; overflow=0.
- 5th write of 7 while full → count=4, overflow=1, error=1. Then 4 reads → data 1,2,3,4 each with a data_valid pulse, 7 never appears; empty=1.
- rd on empty → underflow=1, data holds 4, data_valid=0. Then clr_err with no rd → underflow=0, error=0. Then clr_err & rd on empty same cycle → underflow=1.
- Full FIFO, wr=1 rd=1 with in=5 → data=oldest entry, count stays 4, no overflow. Drain → 5 last out.
- Empty FIFO, wr=1 rd=1 in=6 → count=1, underflow=1, next rd yields 6. Interleaved writes to wrap pointers past 3→0 twice → strict FIFO order preserved.
- Assert reset=0 asynchronously mid-burst with count=3 → outputs reach reset values without clk edge. After release, empty=1 and first read underflows.

Source files
------------

// File: rtl/cola_fifo_ext.sv
// cola_fifo_ext: parametrised synchronous FIFO, 2^W entries of B bits.
// Registered read data with a one-cycle valid strobe, occupancy count,
// programmable almost-full/almost-empty thresholds, and sticky
// overflow/underflow flags with a synchronous clear.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-low reset
//   wr, rd       single-cycle write / read requests (level = one per cycle)
//   in           write data, captured when a write is accepted
//   clr_err      synchronous clear of overflow/underflow
//   data         registered read data, holds between reads
//   data_valid   one-cycle pulse when data was updated by a read
//   count        occupancy 0..2^W
//   full, empty, almost_full, almost_empty   combinational from count
//   overflow, underflow   sticky error flags
//   error        overflow | underflow
module cola_fifo_ext #(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = (1 << W) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] in,
    input  logic         clr_err,
    output logic [B-1:0] data,
    output logic         data_valid,
    output logic [W:0]   count,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         overflow,
    output logic         underflow,
    output logic         error
);

    localparam logic [W:0] FULL_CNT = {1'b1, {W{1'b0}}};
    localparam logic [W:0] AF_CNT   = (W+1)'(AF_LEVEL);
    localparam logic [W:0] AE_CNT   = (W+1)'(AE_LEVEL);

    logic [B-1:0] mem [1 << W];
    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic         rd_ok;
    logic         wr_ok;
    logic         ovf_evt;
    logic         udf_evt;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign error        = overflow | underflow;

    // A read on a full FIFO frees a slot on the same edge, so a
    // simultaneous write is still accepted there.
    assign rd_ok   = rd & ~empty;
    assign wr_ok   = wr & (~full | rd_ok);
    assign ovf_evt = wr & ~wr_ok;
    assign udf_evt = rd & empty;

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                data   <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error event on the same edge as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
